contador_trans: RTL

Parametrised transfer-sequencing counter for the UART/SPI datapath: accepts a start command with a transfer count and base address, steps a register-file address on every completed transfer, and pulses `trans_ready` when the programmed count is reached. It extends the single-run transfer counter with several features: base-address loading, abort, a busy handshake, a per-transaction count, and a saturating cumulative count. It sits between the serial TX/RX engines (source of `cont_trans`) and the shared register file (consumer of `addr2`).

---
 rtl/contador_pkg.sv | 17 +
 rtl/contador_sat.sv | 35 +++
 rtl/contador_trans.sv | 132 +++++++++++++
 3 files changed

// File: rtl/contador_pkg.sv
// Shared types and constants for the contador_trans transfer-sequencing counter.
// Optional auto-restart is enabled by defining CONTADOR_TRANS_RELOAD_EN.
package contador_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } contador_state_t;

    localparam int CONTADOR_N_DEFAULT    = 5;
    localparam int CONTADOR_RX_W_DEFAULT = CONTADOR_N_DEFAULT + 2;

    // All-ones value at which the cumulative transfer count stops.
    localparam logic [CONTADOR_RX_W_DEFAULT-1:0] CONTADOR_SAT_MAX = '1;

endpackage

// File: rtl/contador_sat.sv
// Registered saturating incrementer: counts enabled cycles and holds at all-ones.
module contador_sat
    import contador_pkg::*;
#(
    parameter int W = $bits(CONTADOR_SAT_MAX)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en_i,
    output logic [W-1:0] cnt_o
);

    localparam logic [W-1:0] MAX = '1;
    localparam logic [W-1:0] ONE = W'(1);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (en_i && (cnt_q != MAX)) begin
            cnt_d = cnt_q + ONE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/contador_trans.sv
// Transfer-sequencing counter: steps a register-file address per completed transfer
// and pulses trans_ready at the programmed count. CONTADOR_TRANS_RELOAD_EN adds auto-restart.
module contador_trans
    import contador_pkg::*;
#(
    parameter int N = CONTADOR_N_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         cont_trans,
    input  logic         abort,
    input  logic [N:0]   n_tx_end,
    input  logic [N:0]   addr_base,
`ifdef CONTADOR_TRANS_RELOAD_EN
    input  logic         reload,
`endif
    output logic         busy,
    output logic         trans_ready,
    output logic [N:0]   addr2,
    output logic [N:0]   xfer_cnt,
    output logic [N+1:0] n_rx_end
);

    localparam logic [N:0] ONE = (N+1)'(1);

    contador_state_t state_q, state_d;
    logic [N:0] n_end_q, n_end_d;
    logic [N:0] addr_q, addr_d;
    logic [N:0] xfer_q, xfer_d;
    logic [N:0] xfer_inc;
    logic       busy_q, ready_q;
    logic       inc_rx;
`ifdef CONTADOR_TRANS_RELOAD_EN
    logic [N:0] base_q, base_d;
`endif

    assign xfer_inc = xfer_q + ONE;

    // NOTE: every signal driven here gets its hold value first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        n_end_d = n_end_q;
        addr_d  = addr_q;
        xfer_d  = xfer_q;
        inc_rx  = 1'b0;
`ifdef CONTADOR_TRANS_RELOAD_EN
        base_d  = base_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    n_end_d = n_tx_end;
                    addr_d  = addr_base;
                    xfer_d  = '0;
`ifdef CONTADOR_TRANS_RELOAD_EN
                    base_d  = addr_base;
`endif
                    state_d = (n_tx_end == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                // Abort outranks a coincident transfer pulse: nothing is counted.
                if (abort) begin
                    state_d = IDLE;
                end else if (cont_trans) begin
                    xfer_d = xfer_inc;
                    addr_d = addr_q + ONE;
                    inc_rx = 1'b1;
                    if (xfer_inc == n_end_q) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
`ifdef CONTADOR_TRANS_RELOAD_EN
                if (reload && !abort) begin
                    addr_d  = base_q;
                    xfer_d  = '0;
                    state_d = (n_end_q == '0) ? DONE : RUN;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            n_end_q <= '0;
            addr_q  <= '0;
            xfer_q  <= '0;
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            n_end_q <= n_end_d;
            addr_q  <= addr_d;
            xfer_q  <= xfer_d;
            busy_q  <= (state_d != IDLE);
            ready_q <= (state_d == DONE);
        end
    end

`ifdef CONTADOR_TRANS_RELOAD_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            base_q <= '0;
        end else begin
            base_q <= base_d;
        end
    end
`endif

    contador_sat #(
        .W (N + 2)
    ) u_rx_sat (
        .clk   (clk),
        .rst   (rst),
        .en_i  (inc_rx),
        .cnt_o (n_rx_end)
    );

    assign busy        = busy_q;
    assign trans_ready = ready_q;
    assign addr2       = addr_q;
    assign xfer_cnt    = xfer_q;

endmodule
